// File: rtl/pkt_out_stage.sv
// pkt_out_stage: 4-entry output FIFO with NetFPGA framing check, re-timed out_wr/out_rdy handshake.
// Define PKT_OUT_STAGE_STATS_EN to build the packet/word/error counters; otherwise they read 0.
module pkt_out_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  stats_clr,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [7:0]            err_count,
  output logic [1:0]            frame_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HDR  = 2'b01,
    BODY = 2'b10,
    DROP = 2'b11
  } frame_t;

  // Assertion is immediate; release reaches the rest of the block two edges later.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic [CTRL_WIDTH+DATA_WIDTH-1:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] occ, occ_next;
  frame_t     state;
  logic       full, is_hdr, store, pop, eop, err;

  // A full FIFO rejects the write even if the head is popped in the same cycle.
  assign full     = (occ == 3'd4);
  assign is_hdr   = (in_ctrl != '0);
  assign pop      = (occ != 3'd0) && out_rdy;
  assign store    = in_wr && !full && (is_hdr || state == HDR || state == BODY);
  assign eop      = store && is_hdr && (state == BODY);
  assign err      = in_wr && (full || (state == IDLE && !is_hdr));
  assign occ_next = occ + {2'b00, store} - {2'b00, pop};

  assign frame_state = state;

  // Framing FSM: only words that reach the FIFO check (not full) move the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (in_wr && !full) begin
      case (state)
        IDLE:    state <= is_hdr ? HDR : DROP;
        HDR:     if (!is_hdr) state <= BODY;
        BODY:    if (is_hdr)  state <= IDLE;
        DROP:    if (is_hdr)  state <= HDR;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      in_rdy   <= 1'b0;
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 2'd1;
      if (pop) begin
        rd_ptr               <= rd_ptr + 2'd1;
        {out_ctrl, out_data} <= mem[rd_ptr];
      end
      out_wr <= pop;
      occ    <= occ_next;
      in_rdy <= (occ_next < 3'd3);
    end
  end

  // NOTE: storage is deliberately not reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= {in_ctrl, in_data};
  end

`ifdef PKT_OUT_STAGE_STATS_EN
  logic [CNT_WIDTH-1:0] pkt_q, word_q;
  logic [7:0]           err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q  <= '0;
      word_q <= '0;
      err_q  <= '0;
    end else if (stats_clr) begin
      pkt_q  <= '0;
      word_q <= '0;
      err_q  <= '0;
    end else begin
      if (eop   && pkt_q  != '1) pkt_q  <= pkt_q  + CNT_WIDTH'(1);
      if (store && word_q != '1) word_q <= word_q + CNT_WIDTH'(1);
      if (err   && err_q  != '1) err_q  <= err_q  + 8'd1;
    end
  end

  assign pkt_count  = pkt_q;
  assign word_count = word_q;
  assign err_count  = err_q;
`else
  logic unused_stats;
  assign unused_stats = ^{stats_clr, eop, err};
  assign pkt_count    = '0;
  assign word_count   = '0;
  assign err_count    = '0;
`endif

endmodule
